// File: rtl/imm_gen_unit.sv
// -----------------------------------------------------------------------------
// imm_gen_unit
//
// Decode-stage immediate generator. Each accepted 16-bit word is classified
// and turned into an operand immediate: a shift amount, the implicit
// constants 1 or 0, a short field, or a wide immediate made from the
// EXT_WORDS instruction words that follow a load-immediate opcode. A small
// FSM tracks those extension words and flags them so decode can squash them.
// The result is registered under stall/flush control.
//
// Optional build macro:
//   IMM_SIGN_EXT_EN  defined   -> SHORT immediates are sign-extended
//                    undefined -> SHORT immediates are zero-extended
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   instr_in     fetched instruction word
//   instr_valid  instr_in is valid this cycle
//   stall        decode stalled; every register holds
//   flush        squash; abandon any sequence (wins over stall and accept)
//   ext_word     combinational: this word is extension data, not an instruction
//   busy         registered: FSM is collecting extension words
//   imm_out      registered immediate, DATA_W = 16*EXT_WORDS bits
//   imm_valid    registered: imm_out belongs to the previously accepted instruction
//   imm_kind     registered: 0 SHORT, 1 SHAMT, 2 ONE, 3 ZERO, 4 WIDE
// -----------------------------------------------------------------------------
module imm_gen_unit #(
  parameter int EXT_WORDS = 1,  // legal 1..4
  parameter int SHORT_W   = 8,
  parameter int SHAMT_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               instr_in,
  input  logic                      instr_valid,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      ext_word,
  output logic                      busy,
  output logic [16*EXT_WORDS-1:0]   imm_out,
  output logic                      imm_valid,
  output logic [2:0]                imm_kind
);

  localparam int DATA_W = 16 * EXT_WORDS;
  localparam logic [2:0] CNT_LOAD = 3'(EXT_WORDS);

  typedef enum logic {IDLE, COLLECT} state_t;

  typedef enum logic [2:0] {
    K_SHORT = 3'd0,
    K_SHAMT = 3'd1,
    K_ONE   = 3'd2,
    K_ZERO  = 3'd3,
    K_WIDE  = 3'd4
  } kind_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d, asm_next;
  logic [DATA_W-1:0] imm_q, imm_d;
  kind_t             kind_q, kind_d;
  logic              valid_q, valid_d;

  logic              accept;
  logic              cls_wide;
  kind_t             cls_kind;
  logic [DATA_W-1:0] cls_imm;
  logic [DATA_W-1:0] short_ext;
  logic [DATA_W-1:0] shamt_ext;

  assign accept = instr_valid & ~stall & ~flush;

`ifdef IMM_SIGN_EXT_EN
  assign short_ext = {{(DATA_W-SHORT_W){instr_in[SHORT_W-1]}}, instr_in[SHORT_W-1:0]};
`else
  assign short_ext = {{(DATA_W-SHORT_W){1'b0}}, instr_in[SHORT_W-1:0]};
`endif

  assign shamt_ext = {{(DATA_W-SHAMT_W){1'b0}}, instr_in[SHAMT_W-1:0]};

  // Earlier extension words move up by 16 bits, so after EXT_WORDS shifts the
  // first one sits in the most significant slot. For EXT_WORDS=1 the shift
  // simply discards the (cleared) previous content.
  assign asm_next = (asm_q << 16) | DATA_W'(instr_in);

  // Classification, highest priority first. Only meaningful in IDLE; in
  // COLLECT the word is data, even if it looks like a WIDE opcode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    cls_wide = 1'b0;
    cls_kind = K_SHORT;
    cls_imm  = short_ext;
    if (instr_in[15:11] == 5'b00111) begin
      cls_wide = 1'b1;
      cls_kind = K_WIDE;
      cls_imm  = '0;
    end else if (instr_in[15:11] == 5'b00101) begin
      cls_kind = K_ZERO;
      cls_imm  = '0;
    end else if (instr_in[15:11] == 5'b00010 || instr_in[15:11] == 5'b10000) begin
      cls_kind = K_ONE;
      cls_imm  = DATA_W'(1);
    end else if (instr_in[15:12] == 4'b1010) begin
      cls_kind = K_SHAMT;
      cls_imm  = shamt_ext;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    imm_d   = imm_q;
    kind_d  = kind_q;
    valid_d = valid_q;

    if (flush) begin
      // imm_out and imm_kind deliberately keep their last value.
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (cls_wide) begin
            state_d = COLLECT;
            cnt_d   = CNT_LOAD;
            asm_d   = '0;
            valid_d = 1'b0;
          end else begin
            imm_d   = cls_imm;
            kind_d  = cls_kind;
            valid_d = 1'b1;
          end
        end
        COLLECT: begin
          asm_d   = asm_next;
          cnt_d   = cnt_q - 3'd1;
          valid_d = 1'b0;
          if (cnt_q == 3'd1) begin
            imm_d   = asm_next;
            kind_d  = K_WIDE;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (!stall) begin
      // Bubble: result is consumed, but an open sequence stays open.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      imm_q   <= '0;
      kind_q  <= K_SHORT;
      valid_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      imm_q   <= imm_d;
      kind_q  <= kind_d;
      valid_q <= valid_d;
    end
  end

  // Extension words are flagged even during a flush cycle so decode never
  // mistakes them for instructions.
  assign ext_word  = (state_q == COLLECT) & instr_valid & ~stall;
  assign busy      = (state_q == COLLECT);
  assign imm_out   = imm_q;
  assign imm_valid = valid_q;
  assign imm_kind  = kind_q;

endmodule
